// File: rtl/cbudlce_nch_pkg.sv
// rtl/cbudlce_nch_pkg.sv - shared constants and helpers for the cbudlce_nch counter bank
// Direction/mode constants, load clamp and bitwise majority vote.
package cbudlce_nch_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  function automatic int unsigned clamp_min(input int unsigned value, input int unsigned max_val);
    return (value > max_val) ? max_val : value;
  endfunction

  function automatic logic [31:0] vote(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cbudlce_ch.sv
// rtl/cbudlce_ch.sv - one up/down counter channel with load, clear, wrap/saturate and sticky OVF
// CBUDLCE_TMR_EN selects triplicated, self-correcting Q/OVF state.
module cbudlce_ch
  import cbudlce_nch_pkg::*;
#(
  parameter int unsigned Width  = 4,
  parameter int unsigned MaxVal = (2 ** Width) - 1,
  parameter int unsigned Sat    = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce,
  input  logic             up,
  input  logic             ld,
  input  logic             clr,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [Width-1:0] MAX_Q = Width'(MaxVal);

  logic [Width-1:0] q_nxt;
  logic             ovf_nxt;

  // q above MAX_Q is only reachable by an upset; treat it like the terminal value
  always_comb begin
    q_nxt   = q;
    ovf_nxt = ovf;
    if (clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (ld) begin
      q_nxt = Width'(clamp_min(32'(din), MaxVal));
    end else if (ce) begin
      if (up == DIR_UP) begin
        if (q >= MAX_Q) begin
          q_nxt   = (Sat == MODE_SAT) ? MAX_Q : '0;
          ovf_nxt = 1'b1;
        end else begin
          q_nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          q_nxt   = (Sat == MODE_SAT) ? '0 : MAX_Q;
          ovf_nxt = 1'b1;
        end else begin
          q_nxt = q - 1'b1;
        end
      end
    end
  end

  assign tc = ce & ((up & (q == MAX_Q)) | (~up & (q == '0)));

`ifdef CBUDLCE_TMR_EN
  (* syn_preserve = 1 *) logic [Width-1:0] q_a, q_b, q_c;
  (* syn_preserve = 1 *) logic             ovf_a, ovf_b, ovf_c;

  // every copy takes the voted next state each clock, so one upset heals in a cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_a   <= '0;
      q_b   <= '0;
      q_c   <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
      ovf_c <= 1'b0;
    end else begin
      q_a   <= q_nxt;
      q_b   <= q_nxt;
      q_c   <= q_nxt;
      ovf_a <= ovf_nxt;
      ovf_b <= ovf_nxt;
      ovf_c <= ovf_nxt;
    end
  end

  assign q   = Width'(vote(32'(q_a), 32'(q_b), 32'(q_c)));
  assign ovf = 1'(vote(32'(ovf_a), 32'(ovf_b), 32'(ovf_c)));
`else
  logic [Width-1:0] q_r;
  logic             ovf_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r   <= '0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign q   = q_r;
  assign ovf = ovf_r;
`endif

endmodule

// File: rtl/cbudlce_nch.sv
// rtl/cbudlce_nch.sv - bank of NCh independent cbudlce_ch counters (CBUDLCE_TMR_EN for TMR state)
module cbudlce_nch
  import cbudlce_nch_pkg::*;
#(
  parameter int unsigned Width  = 4,
  parameter int unsigned NCh    = 1,
  parameter int unsigned MaxVal = (2 ** Width) - 1,
  parameter int unsigned Sat    = MODE_WRAP
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCh-1:0]       CE,
  input  logic [NCh-1:0]       UP,
  input  logic [NCh-1:0]       LD,
  input  logic [NCh*Width-1:0] DIN,
  input  logic [NCh-1:0]       CLR,
  output logic [NCh*Width-1:0] Q,
  output logic [NCh-1:0]       TC,
  output logic [NCh-1:0]       OVF
);

  for (genvar i = 0; i < NCh; i++) begin : g_ch
    cbudlce_ch #(
      .Width (Width),
      .MaxVal(MaxVal),
      .Sat   (Sat)
    ) u_ch (
      .CLK(CLK),
      .RST(RST),
      .ce (CE[i]),
      .up (UP[i]),
      .ld (LD[i]),
      .clr(CLR[i]),
      .din(DIN[i*Width +: Width]),
      .q  (Q[i*Width +: Width]),
      .tc (TC[i]),
      .ovf(OVF[i])
    );
  end

endmodule

// File: tb/tb_cbudlce_nch.sv
// tb/tb_cbudlce_nch.sv - directed self-checking bench for cbudlce_nch (wrap and saturate instances)
module tb_cbudlce_nch;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ce, up, ld, clr;
  logic [7:0] din;
  logic [7:0] qw, qs;
  logic [1:0] tcw, tcs, ovfw, ovfs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cbudlce_nch #(.Width(4), .NCh(2), .MaxVal(9), .Sat(0)) dut_w (
    .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LD(ld), .DIN(din), .CLR(clr),
    .Q(qw), .TC(tcw), .OVF(ovfw)
  );

  cbudlce_nch #(.Width(4), .NCh(2), .MaxVal(9), .Sat(1)) dut_s (
    .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LD(ld), .DIN(din), .CLR(clr),
    .Q(qs), .TC(tcs), .OVF(ovfs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 2'b00; up = 2'b00; ld = 2'b00; clr = 2'b00; din = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    ld = 2'b01; din = 8'h05;
    tick();
    ld = 2'b00;
    checks++;
    if (qw[3:0] !== 4'd5) begin errors++; $display("FAIL reset_preload: got %0d expected 5", qw[3:0]); end
    ce = 2'b01; up = 2'b01;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (qw !== 8'h00 || qs !== 8'h00) begin errors++; $display("FAIL reset_async_q: got %h/%h expected 00/00", qw, qs); end
    checks++;
    if (ovfw !== 2'b00 || ovfs !== 2'b00) begin errors++; $display("FAIL reset_async_ovf: got %b/%b expected 00/00", ovfw, ovfs); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (qw[3:0] !== 4'd3 || qs[3:0] !== 4'd3) begin errors++; $display("FAIL reset_release_count: got %0d/%0d expected 3", qw[3:0], qs[3:0]); end
  endtask

  task automatic test_wrap_up();
    do_reset();
    ld = 2'b01; din = 8'h08;
    tick();
    ld = 2'b00; ce = 2'b01; up = 2'b01;
    #1;
    checks++;
    if (tcw[0] !== 1'b0) begin errors++; $display("FAIL wrap_tc_at8: got %b expected 0", tcw[0]); end
    tick();
    checks++;
    if (qw[3:0] !== 4'd9 || tcw[0] !== 1'b1 || ovfw[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_at9: q=%0d tc=%b ovf=%b expected q=9 tc=1 ovf=0", qw[3:0], tcw[0], ovfw[0]);
    end
    tick();
    checks++;
    if (qw[3:0] !== 4'd0 || ovfw[0] !== 1'b1 || tcw[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_to0: q=%0d tc=%b ovf=%b expected q=0 tc=0 ovf=1", qw[3:0], tcw[0], ovfw[0]);
    end
    checks++;
    if (qs[3:0] !== 4'd9 || ovfs[0] !== 1'b1) begin
      errors++; $display("FAIL sat_up_hold9: q=%0d ovf=%b expected q=9 ovf=1", qs[3:0], ovfs[0]);
    end
    tick();
    checks++;
    if (qw[3:0] !== 4'd1 || ovfw[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_ovf_sticky: q=%0d ovf=%b expected q=1 ovf=1", qw[3:0], ovfw[0]);
    end
  endtask

  task automatic test_sat_down();
    do_reset();
    ce = 2'b01; up = 2'b01;
    repeat (4) tick();
    ce = 2'b00; clr = 2'b01;
    tick();
    clr = 2'b00; ce = 2'b01; up = 2'b00;
    #1;
    checks++;
    if (qs[3:0] !== 4'd0 || tcs[0] !== 1'b1) begin errors++; $display("FAIL sat_clr_tc: q=%0d tc=%b expected q=0 tc=1", qs[3:0], tcs[0]); end
    tick();
    checks++;
    if (qs[3:0] !== 4'd0 || ovfs[0] !== 1'b1 || tcs[0] !== 1'b1) begin
      errors++; $display("FAIL sat_down_hold0: q=%0d tc=%b ovf=%b expected q=0 tc=1 ovf=1", qs[3:0], tcs[0], ovfs[0]);
    end
    checks++;
    if (qw[3:0] !== 4'd9 || ovfw[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_down_to9: q=%0d ovf=%b expected q=9 ovf=1", qw[3:0], ovfw[0]);
    end
    clr = 2'b01;
    tick();
    clr = 2'b00; ce = 2'b00;
    checks++;
    if (ovfs[0] !== 1'b0 || qs[3:0] !== 4'd0) begin errors++; $display("FAIL sat_clr_ovf: q=%0d ovf=%b expected q=0 ovf=0", qs[3:0], ovfs[0]); end
  endtask

  task automatic test_priority_clamp();
    do_reset();
    ld = 2'b11; din = 8'h53;
    tick();
    ld = 2'b10; clr = 2'b10; ce = 2'b10; up = 2'b10; din = 8'h70;
    tick();
    checks++;
    if (qw !== 8'h03 || qs !== 8'h03) begin errors++; $display("FAIL prio_clr_wins: got %h/%h expected 03/03", qw, qs); end
    clr = 2'b00; ce = 2'b00; ld = 2'b10; din = 8'hF0;
    tick();
    idle();
    checks++;
    if (qw !== 8'h93 || qs !== 8'h93) begin errors++; $display("FAIL clamp_ld15: got %h/%h expected 93/93", qw, qs); end
    checks++;
    if (ovfw !== 2'b00 || ovfs !== 2'b00) begin errors++; $display("FAIL prio_ovf: got %b/%b expected 00/00", ovfw, ovfs); end
  endtask

  task automatic test_independence();
    do_reset();
    ce = 2'b11; up = 2'b01;
    repeat (12) tick();
    ce = 2'b00;
    #1;
    checks++;
    if (qw !== 8'h82 || ovfw !== 2'b11) begin errors++; $display("FAIL indep_wrap: q=%h ovf=%b expected q=82 ovf=11", qw, ovfw); end
    checks++;
    if (qs !== 8'h09 || ovfs !== 2'b11) begin errors++; $display("FAIL indep_sat: q=%h ovf=%b expected q=09 ovf=11", qs, ovfs); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ld = 2'b01; din = 8'h04; ce = 2'b01; up = 2'b01;
    tick();
    checks++;
    if (qw[3:0] !== 4'd4) begin errors++; $display("FAIL b2b_ld_over_ce: got %0d expected 4", qw[3:0]); end
    ld = 2'b00;
    tick();
    checks++;
    if (qw[3:0] !== 4'd5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", qw[3:0]); end
    ce = 2'b00;
    repeat (2) tick();
    checks++;
    if (qw[3:0] !== 4'd5 || ovfw[0] !== 1'b0) begin errors++; $display("FAIL b2b_hold: q=%0d ovf=%b expected 5/0", qw[3:0], ovfw[0]); end
  endtask

`ifdef CBUDLCE_TMR_EN
  task automatic test_tmr();
    do_reset();
    ld = 2'b01; din = 8'h02;
    tick();
    idle();
    force dut_w.g_ch[0].u_ch.q_b = 4'd4;
    #1;
    checks++;
    if (qw[3:0] !== 4'd2) begin errors++; $display("FAIL tmr_vote: got %0d expected 2", qw[3:0]); end
    release dut_w.g_ch[0].u_ch.q_b;
    tick();
    checks++;
    if (dut_w.g_ch[0].u_ch.q_b !== 4'd2 || qw[3:0] !== 4'd2) begin
      errors++; $display("FAIL tmr_heal: copy=%0d q=%0d expected 2/2", dut_w.g_ch[0].u_ch.q_b, qw[3:0]);
    end
  endtask
`endif

  initial begin
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (qw !== 8'h00 || ovfw !== 2'b00) begin errors++; $display("FAIL reset_initial: q=%h ovf=%b expected 00/00", qw, ovfw); end
    tick();
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority_clamp();
    test_independence();
    test_back_to_back();
`ifdef CBUDLCE_TMR_EN
    test_tmr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
